dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipeline MEM stage (CPU) and a DMA/loader port.
- The memory writes on the rising clock edge and reads combinationally. CPU accesses are served in the same cycle; DMA accesses complete with a registered acknowledge.
- Fixed CPU priority, with a starvation counter that forces a DMA grant. Any cycle the CPU loses arbitration, it is stalled.
- Sits between the EX/MEM pipeline register outputs and the data memory; cpu_stall feeds the pipeline stall logic.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_WAIT, 4, number of consecutive denied DMA cycles after which DMA wins over the CPU (1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clrn  in  1  asynchronous active-low reset.
- cpu_req  in  1  MEM stage requests a load or store this cycle.
- cpu_we  in  1  CPU store enable.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU store data.
- cpu_rdata  out  DW  CPU load data, combinational from mem_rdata.
- cpu_stall  out  1  CPU request not served this cycle; pipeline holds.
- dma_req  in  1  DMA request; held with stable we/addr/wdata until dma_ack.
- dma_we  in  1  DMA write enable.
- dma_addr  in  AW  DMA address.
- dma_wdata  in  DW  DMA write data.
- dma_ack  out  1  registered; one-cycle pulse the cycle after the DMA access.
- dma_rdata  out  DW  registered DMA read data, valid while dma_ack=1.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  DW  memory combinational read data.

Behaviour:
- State: fsm in {IDLE, DACK}; wait_cnt is 4 bits.
- Reset (clrn=0, asynchronous) sets fsm=IDLE, wait_cnt=0, dma_ack=0, dma_rdata=0. mem_we is forced to 0 while clrn=0.
- dma_elig = dma_req & (fsm==IDLE).
- Owner selection, combinational, evaluated each cycle in priority order:
  - DMA if dma_elig & (wait_cnt>=MAX_WAIT);
  - else CPU if cpu_req;
  - else DMA if dma_elig;
  - else NONE.
- Memory bus by owner:
  - CPU: mem_addr/mem_wdata/mem_we come from the cpu_* inputs.
  - DMA: mem_addr/mem_wdata/mem_we come from the dma_* inputs.
  - NONE: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=0.
- cpu_rdata = mem_rdata at all times; it is meaningful only when owner=CPU.
- cpu_stall = cpu_req & (owner==DMA), combinational. No other cause of stall exists.
- On a clock edge with owner=DMA:
  - fsm goes to DACK; dma_ack goes to 1; wait_cnt goes to 0.
  - dma_rdata captures mem_rdata on reads; it is left unchanged on writes.
- In DACK:
  - dma_ack=1 for exactly this cycle and DMA is ineligible. The requester may drop dma_req or present a new request.
  - Next state is IDLE; dma_ack returns to 0.
- wait_cnt:
  - increments (saturating at 15) on each edge where dma_elig=1 and owner!=DMA;
  - clears when owner=DMA;
  - holds otherwise.
- DMA latency:
  - uncontended: access in cycle t, ack in t+1;
  - worst case: ack by t+MAX_WAIT+1 after the request is first eligible.
- CPU bound: the CPU is stalled at most 1 consecutive cycle, because DACK makes DMA ineligible on the following cycle.
- Back-to-back DMA: minimum spacing is 2 cycles per access (access, ack).
- Simultaneous CPU and DMA store to the same address: only the owner's write reaches memory. The loser retries later and its data lands last.
- Reset during DACK or mid-wait: state clears; an outstanding dma_ack is dropped. The DMA requester re-issues.
- dma_req deasserted before ack is illegal; the bench flags it as a protocol error and the design behaviour is unspecified.

Test Plan:
- Reset: hold clrn=0 with cpu_req=1, cpu_we=1 -> mem_we=0, dma_ack=0, dma_rdata=0, cpu_stall=0.
- CPU only: store 0xDEADBEEF to 0x10, then load 0x10 -> mem_we=1 during the store cycle; cpu_rdata=0xDEADBEEF in the load cycle; cpu_stall never set.
- DMA only: write 0x1234 to 0x20 (cycle t) -> dma_ack=1 at t+1, 0 at t+2. DMA read of 0x20 -> dma_rdata=0x1234 with ack.
- Contention, MAX_WAIT=4: cpu_req held 1 continuously, dma_req from t0 -> CPU owns t0..t3; DMA owns t4 with cpu_stall=1 only at t4; dma_ack at t5; CPU served at t5.
- DMA re-request during DACK: dma_req held high across ack -> no DMA access in the DACK cycle; next DMA access ≥2 cycles after the previous one; wait_cnt restarts from 0.
- Async reset mid-wait (wait_cnt=3, clrn pulsed low between edges) -> wait_cnt=0, fsm=IDLE immediately; the DMA then needs a full MAX_WAIT against a busy CPU.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundles the CPU, DMA and data-memory buses that meet at the data-memory arbiter.
// The slave modport is the arbiter's view; the master modport drives the arbiter.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_ack;
    logic [DW-1:0] dma_rdata;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_stall,
        output dma_ack, dma_rdata,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_stall,
        input  dma_ack, dma_rdata,
        input  mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU has fixed priority, DMA is forced in after
// MAX_WAIT consecutive denied cycles and acknowledged one cycle after its access.
//
// state | meaning
// IDLE  | DMA may be granted this cycle
// DACK  | dma_ack is high; DMA is ineligible for this one cycle
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            clrn,
    dmem_arbiter_if.slave   bus
);
    typedef enum logic {
        IDLE = 1'b0,
        DACK = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    state_t        state_q, state_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic          dma_ack_q, dma_ack_d;
    logic [DW-1:0] dma_rdata_q, dma_rdata_d;

    owner_t        owner;
    logic          dma_elig;
    logic [AW-1:0] mem_addr_sel;
    logic [DW-1:0] mem_wdata_sel;
    logic          mem_we_sel;

    always_comb begin
        dma_elig = bus.dma_req && (state_q == IDLE);
        owner    = OWN_NONE;
        if (dma_elig && (wait_cnt_q >= MAX_WAIT_C)) begin
            owner = OWN_DMA;
        end else if (bus.cpu_req) begin
            owner = OWN_CPU;
        end else if (dma_elig) begin
            owner = OWN_DMA;
        end
    end

    // With no owner the bus idles on the CPU address so the read path stays quiet.
    always_comb begin
        mem_addr_sel  = bus.cpu_addr;
        mem_wdata_sel = bus.cpu_wdata;
        mem_we_sel    = 1'b0;
        case (owner)
            OWN_CPU: begin
                mem_addr_sel  = bus.cpu_addr;
                mem_wdata_sel = bus.cpu_wdata;
                mem_we_sel    = bus.cpu_we;
            end
            OWN_DMA: begin
                mem_addr_sel  = bus.dma_addr;
                mem_wdata_sel = bus.dma_wdata;
                mem_we_sel    = bus.dma_we;
            end
            default: begin
                mem_addr_sel  = bus.cpu_addr;
                mem_wdata_sel = bus.cpu_wdata;
                mem_we_sel    = 1'b0;
            end
        endcase
    end

    assign bus.mem_addr  = mem_addr_sel;
    assign bus.mem_wdata = mem_wdata_sel;
    assign bus.mem_we    = mem_we_sel & clrn;
    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.cpu_stall = bus.cpu_req && (owner == OWN_DMA);
    assign bus.dma_ack   = dma_ack_q;
    assign bus.dma_rdata = dma_rdata_q;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        dma_ack_d   = 1'b0;
        dma_rdata_d = dma_rdata_q;

        case (state_q)
            IDLE: begin
                if (owner == OWN_DMA) begin
                    state_d   = DACK;
                    dma_ack_d = 1'b1;
                    if (!bus.dma_we) begin
                        dma_rdata_d = bus.mem_rdata;
                    end
                end
            end
            DACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (owner == OWN_DMA) begin
            wait_cnt_d = 4'd0;
        end else if (dma_elig && (wait_cnt_q != 4'hF)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 4'd0;
            dma_ack_q   <= 1'b0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            dma_ack_q   <= dma_ack_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a cycle-level reference of the ownership rules
// predicts the bus, stall and acknowledge behaviour; a monitor compares each cycle.
module tb_dmem_arbiter;
    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 4;

    logic clk  = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    // Environment memory: combinational read, write on rising edge.
    logic [31:0] mem_arr [256] = '{default: '0};
    assign bus.mem_rdata = mem_arr[bus.mem_addr[9:2]];
    always @(posedge clk) begin
        if (bus.mem_we) mem_arr[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end

    typedef struct {
        int          cyc;
        bit          stall;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk_rd;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] rdata;
    } ack_t;

    exp_t expq[$];
    ack_t ackq[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   run      = 1'b0;
    bit   rst_this_cyc = 1'b0;
    int   stall_log[$];

    // Reference model state, in terms of the ownership rules.
    logic [31:0] ref_mem [256] = '{default: '0};
    int          m_denied  = 0;
    bit          m_in_ack  = 1'b0;
    logic [31:0] m_rdata   = '0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endfunction

    function automatic int idx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    task automatic drive_cycle(input bit creq, input bit cwe, input logic [31:0] caddr,
                               input logic [31:0] cwdata, input bit dreq, input bit dwe,
                               input logic [31:0] daddr, input logic [31:0] dwdata,
                               input bit rst_pulse);
        exp_t e;
        ack_t a;
        bit   dma_can;
        int   own;
        @(negedge clk);
        cyc++;
        rst_this_cyc  = rst_pulse;
        bus.cpu_req   = creq;
        bus.cpu_we    = cwe;
        bus.cpu_addr  = caddr;
        bus.cpu_wdata = cwdata;
        bus.dma_req   = dreq;
        bus.dma_we    = dwe;
        bus.dma_addr  = daddr;
        bus.dma_wdata = dwdata;
        if (rst_pulse) begin
            #1 clrn = 1'b0;
            m_denied = 0;
            m_in_ack = 1'b0;
            m_rdata  = '0;
            ackq.delete();
            #1 clrn = 1'b1;
            #1;
        end else begin
            #3;
        end
        dma_can = dreq && !m_in_ack;
        own = (dma_can && (m_denied >= MAX_WAIT || !creq)) ? 2 : (creq ? 1 : 0);
        e.cyc    = cyc;
        e.stall  = creq && (own == 2);
        e.we     = (own == 1) ? cwe : ((own == 2) ? dwe : 1'b0);
        e.addr   = (own == 2) ? daddr : caddr;
        e.wdata  = (own == 2) ? dwdata : cwdata;
        e.chk_rd = (own == 1) && !cwe;
        e.rdata  = ref_mem[idx(caddr)];
        expq.push_back(e);
        m_in_ack = 1'b0;
        if (own == 2) begin
            if (!dwe) m_rdata = ref_mem[idx(daddr)];
            a.due   = cyc + 1;
            a.rdata = m_rdata;
            ackq.push_back(a);
            m_denied = 0;
            m_in_ack = 1'b1;
        end else if (dma_can && m_denied < 15) begin
            m_denied++;
        end
        if (e.we) ref_mem[idx(e.addr)] = e.wdata;
    endtask

    task automatic idle_cycle();
        drive_cycle(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    endtask

    // Monitor: samples one time unit before each rising edge.
    initial begin
        exp_t e;
        ack_t a;
        bit   prev_pend;
        int   stall_run;
        prev_pend = 1'b0;
        stall_run = 0;
        forever begin
            @(negedge clk);
            #4;
            if (run) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL exp_queue cyc=%0d actual=empty required=entry", cyc);
                end else begin
                    e = expq.pop_front();
                    chk("cpu_stall", 32'(bus.cpu_stall), 32'(e.stall));
                    chk("mem_we",    32'(bus.mem_we),    32'(e.we));
                    chk("mem_addr",  bus.mem_addr,  e.addr);
                    chk("mem_wdata", bus.mem_wdata, e.wdata);
                    if (e.chk_rd) chk("cpu_rdata", bus.cpu_rdata, e.rdata);
                end
                if (ackq.size() > 0 && ackq[0].due == cyc) begin
                    a = ackq.pop_front();
                    chk("dma_ack",   32'(bus.dma_ack), 32'd1);
                    chk("dma_rdata", bus.dma_rdata, a.rdata);
                end else begin
                    chk("dma_ack_idle", 32'(bus.dma_ack), 32'd0);
                end
                if (bus.cpu_stall) begin
                    stall_log.push_back(cyc);
                    stall_run++;
                    chk("stall_run_le1", 32'(stall_run <= 1), 32'd1);
                end else begin
                    stall_run = 0;
                end
                if (prev_pend && !rst_this_cyc)
                    chk("dma_protocol", 32'(bus.dma_req | bus.dma_ack), 32'd1);
                prev_pend = bus.dma_req && !bus.dma_ack;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int bad;
        bit d_active, dwe, creq, cwe, rp;
        logic [31:0] daddr, dwd, caddr, cwd;

        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 32'h10;
        bus.cpu_wdata = 32'h5555_AAAA;
        bus.dma_req   = 1'b0;
        bus.dma_we    = 1'b0;
        bus.dma_addr  = 32'h0;
        bus.dma_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
        chk("rst_dma_ack",   32'(bus.dma_ack),   32'd0);
        chk("rst_dma_rdata", bus.dma_rdata,      32'd0);
        chk("rst_cpu_stall", 32'(bus.cpu_stall), 32'd0);
        @(negedge clk);
        #2 clrn = 1'b1;
        #4 run = 1'b1;

        // CPU only
        drive_cycle(1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'h0, 0);
        drive_cycle(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        idle_cycle();

        // DMA only: write then read back
        drive_cycle(0, 0, 32'h0, 32'h0, 1, 1, 32'h20, 32'h1234, 0);
        idle_cycle();
        idle_cycle();
        drive_cycle(0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0, 0);
        idle_cycle();
        idle_cycle();

        // Contention with DMA re-requesting across the ack
        t0 = cyc + 1;
        stall_log.delete();
        for (int i = 0; i < 12; i++) begin
            drive_cycle(1, i[0], 32'(($urandom_range(0, 15)) * 4), $urandom,
                        (i != 11), 1'b1, (i <= 4) ? 32'h40 : 32'h44,
                        (i <= 4) ? 32'hA5A5_0001 : 32'hA5A5_0002, 0);
        end
        #3;
        chk("contention_stall_count", 32'(stall_log.size()), 32'd2);
        chk("contention_stall_first",  32'((stall_log.size() > 0) ? stall_log[0] : -1), 32'(t0 + 4));
        chk("contention_stall_second", 32'((stall_log.size() > 1) ? stall_log[1] : -1), 32'(t0 + 10));
        idle_cycle();

        // Asynchronous reset after three denied cycles
        t0 = cyc + 1;
        stall_log.delete();
        for (int i = 0; i < 9; i++) begin
            drive_cycle(1, 0, 32'h10, 32'h0, (i <= 7), 1'b0, 32'h20, 32'h0, (i == 3));
        end
        #3;
        chk("midwait_stall_count", 32'(stall_log.size()), 32'd1);
        chk("midwait_stall_cycle", 32'((stall_log.size() > 0) ? stall_log[0] : -1), 32'(t0 + 7));
        idle_cycle();

        // Reset landing in the ack cycle drops the ack
        drive_cycle(0, 0, 32'h0, 32'h0, 1, 0, 32'h10, 32'h0, 0);
        drive_cycle(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 1);
        #3;
        chk("dack_reset_rdata", bus.dma_rdata, 32'd0);
        idle_cycle();

        // Randomized traffic
        d_active = 1'b0;
        dwe = 1'b0; daddr = '0; dwd = '0;
        for (int n = 0; n < 3000; n++) begin
            if (m_in_ack) begin
                d_active = ($urandom_range(0, 1) == 1);
                dwe   = ($urandom_range(0, 1) == 1);
                daddr = 32'($urandom_range(0, 15) * 4);
                dwd   = $urandom;
            end else if (!d_active && $urandom_range(0, 3) == 0) begin
                d_active = 1'b1;
                dwe   = ($urandom_range(0, 1) == 1);
                daddr = 32'($urandom_range(0, 15) * 4);
                dwd   = $urandom;
            end
            creq  = ($urandom_range(0, 9) < 7);
            cwe   = ($urandom_range(0, 1) == 1);
            caddr = 32'($urandom_range(0, 15) * 4);
            cwd   = $urandom;
            rp    = ($urandom_range(0, 299) == 0);
            drive_cycle(creq, cwe, caddr, cwd, d_active, dwe, daddr, dwd, rp);
        end
        #3;
        run = 1'b0;

        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem_arr[i] !== ref_mem[i]) bad++;
        end
        chk("mem_contents_bad_words", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
